twiddle_gen: RTL and testbench
==============================

// Module: twiddle_gen
// PURPOSE
//  Streams the twiddle-factor operand T into the complex twiddle multiplier of the radix-2 FFT datapath.
//  - On start, emits N/2 twiddles W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for one DIT stage, in butterfly order.
//  - Output word: packed {Tr[23:12], Ti[11:0]}, signed, 10 fractional bits (1.0 = 12'h400).
//  - Values come from a quarter-wave cosine table and octant-free symmetry logic.
// PARAMETERS
//  N_LOG2  6   log2 of FFT size N (N = 64 by default); N_LOG2 >= 3
//  W       12  width of each real/imaginary component
//  FRAC    10  fractional bits of each component
// PORTS
//  clk      in   1         rising-edge clock
//  reset    in   1         asynchronous, active-low; clears all state
//  start    in   1         begin a stage sequence; sampled only while busy=0
//  stage    in   $clog2(N_LOG2)  DIT stage s, 0..N_LOG2-1; values >= N_LOG2 are treated as N_LOG2-1
//  ready    in   1         consumer accepts out this cycle when valid=1
//  valid    out  1         out holds a valid twiddle
//  out      out  2*W       {Tr, Ti}
//  k_index  out  N_LOG2-1  exponent k of the word on out
//  last     out  1         marks the final (N/2-th) twiddle of the sequence
//  busy     out  1         a sequence is in progress
// BEHAVIOUR
//  - Reset values: valid=0, out=0, k_index=0, last=0, busy=0; FSM goes to IDLE, counters cleared.
//  - FSM states:
//    - IDLE: start=1 latches min(stage, N_LOG2-1) into s, clears butterfly counter b, moves to RUN, busy=1.
//    - RUN: b runs 0..N/2-1; each b produces k = (b mod 2^s) << (N_LOG2-1-s).
//  - Pipeline: counter -> ROM/symmetry register -> output register (2 stages).
//    - First valid appears 2 cycles after the cycle start is accepted.
//  - Handshake: a word transfers when valid & ready.
//    - While valid & ~ready, the whole pipeline stalls and out/k_index/last stay stable.
//    - No index is skipped or repeated.
//    - With ready held at 1, one word is produced per cycle.
//  - last=1 together with the word for b=N/2-1.
//  - When that word is accepted: busy drops, valid drops the next cycle (no other word is in flight), FSM returns to IDLE.
//  - start while busy=1 is ignored. start on the same cycle as the final handshake is also ignored; it must be reasserted.
//  - Cosine table: C[i] = round(2^FRAC * cos(2*pi*i/N)), i = 0..N/4.
//    - k <= N/4: Tr = C[k], Ti = -C[N/4-k].
//    - k >  N/4: Tr = -C[N/2-k], Ti = -C[k-N/4].
//  - Negation is two's complement at width W and cannot overflow (|C| <= 2^FRAC < 2^(W-1)).
//  - Reset asserted mid-sequence aborts immediately: all outputs return to reset values, and no partial word appears after release.
// CONFIGURATION
//  - TWIDDLE_CONJ_EN defined:
//    - Adds input port inverse (1 bit), latched together with stage at start.
//    - inverse=1 emits the conjugate (Ti sign flipped) for IFFT use.
//  - TWIDDLE_CONJ_EN undefined: the port is absent and only forward twiddles are emitted.
// STRUCTURE
//  - Shared package twiddle_pkg holds:
//    - the N_LOG2/W/FRAC defaults;
//    - the packed-word field offsets (TR_MSB=23, TR_LSB=12, TI_MSB=11, TI_LSB=0);
//    - the FSM state encoding (IDLE, RUN);
//    - a constant function for C[i].
//  - Sub-module twiddle_rom: quarter-wave cosine table with two registered read ports (index for Tr and index for Ti).
//  - twiddle_gen holds the FSM, counter, symmetry muxing/negation and handshake.
// TESTING
//  - N=64, stage=0, ready=1 -> 32 words, all 24'h400000, k_index=0; last only on the 32nd word.
//  - stage=1 -> words alternate 24'h400000 (k=0) and 24'h000C00 (k=16).
//  - stage=5 -> k=0..31 in order; k=8 gives 24'h2D4D2C; k=16 gives 24'h000C00; k=24 gives 24'hD2CD2C.
//  - stage=5, ready low 3 cycles while k=5 is on out -> out/k_index stable; the next accepted word is k=6.
//  - reset asserted at word 10 of stage 5 -> outputs zero immediately; after release a new start restarts at k=0.
//  - TWIDDLE_CONJ_EN, inverse=1, stage=5 -> k=16 gives 24'h000400; k=8 gives 24'h2D42D4.

Source files
------------

// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared definitions for the radix-2 FFT twiddle generator.
//   - default sizing (N_LOG2/W/FRAC)
//   - packed output word field offsets ({Tr, Ti})
//   - FSM state encoding
//   - cos_tab(): elaboration-time quarter-wave cosine value C[i]
// Optional feature macro used by the block: TWIDDLE_CONJ_EN (see twiddle_gen).
package twiddle_pkg;

  localparam int N_LOG2_DEF = 6;
  localparam int W_DEF      = 12;
  localparam int FRAC_DEF   = 10;

  localparam int TR_MSB = 23;
  localparam int TR_LSB = 12;
  localparam int TI_MSB = 11;
  localparam int TI_LSB = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // pi scaled by 2^30
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(2^frac * cos(2*pi*i/2^n_log2)) for 0 <= i <= 2^n_log2/4.
  // Pure integer Taylor series in Q30 so the table is computed at elaboration
  // without real arithmetic; the angle never exceeds pi/2 so 12 terms are
  // far more than enough for exact rounding at 10 fractional bits.
  function automatic int cos_tab(input int i, input int n_log2, input int frac);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (PI_Q30 * 64'sd2 * longint'(i)) >>> n_log2;
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    acc  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    return int'((acc + (64'sd1 <<< (29 - frac))) >>> (30 - frac));
  endfunction

endpackage

// File: rtl/twiddle_if.sv
// twiddle_if: stream interface between the twiddle generator and its consumer.
//   start/stage[/inverse] : sequence request (consumer -> generator)
//   ready                 : consumer accepts out when valid=1
//   valid/out/k_index/last/busy : twiddle stream and status (generator -> consumer)
// modport master = generator side, slave = consumer side.
// TWIDDLE_CONJ_EN adds the 1-bit 'inverse' request signal.
interface twiddle_if import twiddle_pkg::*; #(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int W      = W_DEF
) ();

  logic                        start;
  logic [$clog2(N_LOG2)-1:0]   stage;
  logic                        ready;
  logic                        valid;
  logic [2*W-1:0]              out;
  logic [N_LOG2-2:0]           k_index;
  logic                        last;
  logic                        busy;

`ifdef TWIDDLE_CONJ_EN
  logic                        inverse;

  modport master (input start, stage, inverse, ready,
                  output valid, out, k_index, last, busy);
  modport slave  (output start, stage, inverse, ready,
                  input valid, out, k_index, last, busy);
`else
  modport master (input start, stage, ready,
                  output valid, out, k_index, last, busy);
  modport slave  (output start, stage, ready,
                  input valid, out, k_index, last, busy);
`endif

endinterface

// File: rtl/twiddle_rom.sv
// twiddle_rom: quarter-wave cosine table C[0..N/4] with two registered read
// ports sharing one enable (port a feeds Tr, port b feeds Ti).
//   clk, reset (async active-low), i_en (advance), i_addr_a/i_addr_b (index),
//   o_data_a/o_data_b (C[index], unsigned magnitude, FRAC fractional bits).
module twiddle_rom import twiddle_pkg::*; #(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int W      = W_DEF,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [N_LOG2-2:0] i_addr_a,
  input  logic [N_LOG2-2:0] i_addr_b,
  output logic [W-1:0]      o_data_a,
  output logic [W-1:0]      o_data_b
);

  localparam int QTR = 1 << (N_LOG2 - 2);

  logic [W-1:0] w_tab [0:QTR];
  logic [W-1:0] r_data_a;
  logic [W-1:0] r_data_b;

  for (genvar g = 0; g <= QTR; g++) begin : g_tab
    localparam int C_VAL = cos_tab(g, N_LOG2, FRAC);
    assign w_tab[g] = C_VAL[W-1:0];
  end

  // Registered table reads; hold while the pipeline is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (i_en) begin
      r_data_a <= w_tab[i_addr_a];
      r_data_b <= w_tab[i_addr_b];
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams N/2 twiddles W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N)
// for one radix-2 DIT stage, in butterfly order, as {Tr, Ti} signed words.
//   clk   : rising-edge clock
//   reset : asynchronous active-low, clears all state
//   bus   : twiddle_if.master (start/stage[/inverse]/ready in,
//           valid/out/k_index/last/busy out)
// Pipeline: butterfly counter -> ROM + symmetry register -> output register.
// Build option TWIDDLE_CONJ_EN: latch 'inverse' at start and emit conjugate
// twiddles (Ti sign flipped) when it is set.
module twiddle_gen import twiddle_pkg::*; #(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int W      = W_DEF,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic     clk,
  input  logic     reset,
  twiddle_if.master bus
);

  localparam int KW      = N_LOG2 - 1;
  localparam int SW      = $clog2(N_LOG2);
  localparam int QTR_I   = 1 << (N_LOG2 - 2);
  localparam int HALF_I  = 1 << (N_LOG2 - 1);
  localparam int SMAX_I  = N_LOG2 - 1;
  localparam logic [KW:0]   QTR    = QTR_I[KW:0];
  localparam logic [KW:0]   HALF   = HALF_I[KW:0];
  localparam logic [KW-1:0] B_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_MAX  = SMAX_I[SW-1:0];

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [KW-1:0]   r_b;
  logic            r_cnt_act;
  logic            r_v1;
  logic [KW-1:0]   r_k1;
  logic            r_last1;
  logic            r_neg_r1;
  logic            r_neg_i1;
  logic            r_valid;
  logic [2*W-1:0]  r_out;
  logic [KW-1:0]   r_k;
  logic            r_last;
  logic            r_busy;

  logic [SW-1:0]   w_stage_c;
  logic [SW-1:0]   w_shift;
  logic [KW-1:0]   w_mask;
  logic [KW-1:0]   w_k;
  logic [KW:0]     w_kx;
  logic [KW-1:0]   w_addr_r;
  logic [KW-1:0]   w_addr_i;
  logic            w_neg_r;
  logic            w_inv;
  logic            w_adv;
  logic            w_done;
  logic [W-1:0]    w_rom_r;
  logic [W-1:0]    w_rom_i;
  logic [W-1:0]    w_tr;
  logic [W-1:0]    w_ti;
  logic [2*W-1:0]  w_word;

  // The whole pipeline moves unless a valid word is waiting on the consumer
  assign w_adv  = ~r_valid | bus.ready;
  assign w_done = r_valid & bus.ready & r_last;

  // Out-of-range stage requests fold onto the final stage
  always_comb begin
    if (bus.stage > S_MAX) begin
      w_stage_c = S_MAX;
    end else begin
      w_stage_c = bus.stage;
    end
  end

  // k = (b mod 2^s) << (N_LOG2-1-s), then map k onto the quarter-wave table
  always_comb begin
    w_shift = S_MAX - r_s;
    w_mask  = (KW'(1) << r_s) - KW'(1);
    w_k     = (r_b & w_mask) << w_shift;
    w_kx    = {1'b0, w_k};
    if (w_kx <= QTR) begin
      w_addr_r = w_k;
      w_addr_i = KW'(QTR - w_kx);
      w_neg_r  = 1'b0;
    end else begin
      w_addr_r = KW'(HALF - w_kx);
      w_addr_i = KW'(w_kx - QTR);
      w_neg_r  = 1'b1;
    end
  end

`ifdef TWIDDLE_CONJ_EN
  logic r_inv;

  // Direction is captured with the stage when a sequence is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inv <= 1'b0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_inv <= bus.inverse;
    end
  end

  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif

  twiddle_rom #(
    .N_LOG2 (N_LOG2),
    .W      (W),
    .FRAC   (FRAC)
  ) u_rom (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_adv & r_cnt_act),
    .i_addr_a (w_addr_r),
    .i_addr_b (w_addr_i),
    .o_data_a (w_rom_r),
    .o_data_b (w_rom_i)
  );

  // Sign application on table magnitudes; |C| <= 2^FRAC so this never wraps
  always_comb begin
    if (r_neg_r1) begin
      w_tr = -w_rom_r;
    end else begin
      w_tr = w_rom_r;
    end
    if (r_neg_i1) begin
      w_ti = -w_rom_i;
    end else begin
      w_ti = w_rom_i;
    end
  end

  if (W == W_DEF) begin : g_pack_fixed
    // Pack using the fixed field offsets of the default word layout
    always_comb begin
      w_word                 = '0;
      w_word[TR_MSB:TR_LSB]  = w_tr;
      w_word[TI_MSB:TI_LSB]  = w_ti;
    end
  end else begin : g_pack_generic
    assign w_word = {w_tr, w_ti};
  end

  // FSM, butterfly counter, symmetry register stage and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_b       <= '0;
      r_cnt_act <= 1'b0;
      r_v1      <= 1'b0;
      r_k1      <= '0;
      r_last1   <= 1'b0;
      r_neg_r1  <= 1'b0;
      r_neg_i1  <= 1'b0;
      r_valid   <= 1'b0;
      r_out     <= '0;
      r_k       <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_s       <= w_stage_c;
            r_b       <= '0;
            r_cnt_act <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          // Start in this cycle is deliberately not looked at
          if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_adv) begin
        if (r_cnt_act) begin
          r_v1     <= 1'b1;
          r_k1     <= w_k;
          r_last1  <= (r_b == B_LAST);
          r_neg_r1 <= w_neg_r;
          r_neg_i1 <= ~w_inv;
          r_b      <= r_b + KW'(1);
          if (r_b == B_LAST) begin
            r_cnt_act <= 1'b0;
          end
        end else begin
          r_v1 <= 1'b0;
        end
        r_valid <= r_v1;
        r_last  <= r_v1 & r_last1;
        if (r_v1) begin
          r_out <= w_word;
          r_k   <= r_k1;
        end
      end
    end
  end

  assign bus.valid   = r_valid;
  assign bus.out     = r_out;
  assign bus.k_index = r_k;
  assign bus.last    = r_last;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench for twiddle_gen (N=64, W=12, FRAC=10).
// Stimulus pushes expected {word, k, last} entries; a negedge monitor pops and
// compares on every valid&ready transfer.
module tb_twiddle_gen;
  import twiddle_pkg::*;

  localparam int  NL = 6;
  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic [23:0] w;
    logic [4:0]  k;
    logic        last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  twiddle_if #(.N_LOG2(NL), .W(12)) bus();

  twiddle_gen #(.N_LOG2(NL), .W(12), .FRAC(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int cq(input int i);
    return $rtoi($floor(1024.0 * $cos(2.0 * PI * i / 64.0) + 0.5));
  endfunction

  // Reference twiddle; the hand-derived words override the formula where known
  function automatic logic [23:0] model(input int k, input bit inv);
    int tr;
    int ti;
    if (k <= 16) begin
      tr = cq(k);
      ti = -cq(16 - k);
    end else begin
      tr = -cq(32 - k);
      ti = -cq(k - 16);
    end
    if (inv) ti = -ti;
    if (!inv && k == 0)  return 24'h400000;
    if (!inv && k == 8)  return 24'h2D4D2C;
    if (!inv && k == 16) return 24'h000C00;
    if (!inv && k == 24) return 24'hD2CD2C;
    if (inv && k == 8)   return 24'h2D42D4;
    if (inv && k == 16)  return 24'h000400;
    return {tr[11:0], ti[11:0]};
  endfunction

  task automatic push_seq(input int s, input bit inv);
    int se;
    se = (s > 5) ? 5 : s;
    for (int b = 0; b < 32; b++) begin
      int   k;
      exp_t e;
      k      = (b % (1 << se)) << (5 - se);
      e.w    = model(k, inv);
      e.k    = k[4:0];
      e.last = (b == 31);
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: one pop per transfer
  always @(negedge clk) begin
    if (rst_n && bus.valid && bus.ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got k=%0d word 0x%0h, expected no transfer", bus.k_index, bus.out);
      end else begin
        mon_e = sb.pop_front();
        check("word", {8'h00, bus.out}, {8'h00, mon_e.w});
        check("k_index", {27'd0, bus.k_index}, {27'd0, mon_e.k});
        check("last", {31'd0, bus.last}, {31'd0, mon_e.last});
      end
    end
  end

  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stage = s[2:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_seq();
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (bus.busy && cyc < 200);
    check("done_in_time", cyc < 200, 1'b1);
    check("valid_after_done", bus.valid, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("busy_idle", bus.busy, 1'b0);
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic run_seq(input int s, input bit inv, input bit poke_busy, input bit poke_last);
    int cyc = 0;
    push_seq(s, inv);
`ifdef TWIDDLE_CONJ_EN
    bus.inverse = inv;
`endif
    pulse_start(s);
    check("lat_c1_valid", bus.valid, 1'b0);
    @(posedge clk); #1;
    check("lat_c2_valid", bus.valid, 1'b0);
    @(posedge clk); #1;
    check("lat_c3_valid", bus.valid, 1'b1);
    check("busy_run", bus.busy, 1'b1);
    if (poke_busy) begin
      bus.start = 1'b1;
      bus.stage = 3'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stage = 3'd0;
    end
    if (poke_last) begin
      while (!(bus.valid && bus.last) && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("find_last", cyc < 200, 1'b1);
      bus.start = 1'b1;
      bus.stage = 3'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_last", bus.busy, 1'b0);
      check("valid_after_last", bus.valid, 1'b0);
    end
    finish_seq();
  endtask

  task automatic stall_test();
    int cyc = 0;
    push_seq(5, 1'b0);
    pulse_start(5);
    while (!(bus.valid && bus.k_index == 5'd5) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall_find_k5", cyc < 100, 1'b1);
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_out", {8'h00, bus.out}, {8'h00, model(5, 1'b0)});
      check("stall_k", {27'd0, bus.k_index}, 32'd5);
      check("stall_valid", bus.valid, 1'b1);
    end
    bus.ready = 1'b1;
    finish_seq();
  endtask

  task automatic reset_test();
    int cyc = 0;
    push_seq(5, 1'b0);
    pulse_start(5);
    while (!(bus.valid && bus.k_index == 5'd10) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_find_k10", cyc < 100, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_valid", bus.valid, 1'b0);
    check("rst_mid_out", {8'h00, bus.out}, 32'd0);
    check("rst_mid_k", {27'd0, bus.k_index}, 32'd0);
    check("rst_mid_last", bus.last, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", bus.valid, 1'b0);
      check("post_rst_busy", bus.busy, 1'b0);
    end
    run_seq(5, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected end before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.stage = 3'd0;
    bus.ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
    bus.inverse = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid, 1'b0);
    check("rst_out", {8'h00, bus.out}, 32'd0);
    check("rst_k", {27'd0, bus.k_index}, 32'd0);
    check("rst_last", bus.last, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;

    run_seq(0, 1'b0, 1'b1, 1'b0);
    run_seq(1, 1'b0, 1'b0, 1'b1);
    run_seq(5, 1'b0, 1'b0, 1'b0);
    run_seq(7, 1'b0, 1'b0, 1'b0);
    stall_test();
    reset_test();
`ifdef TWIDDLE_CONJ_EN
    run_seq(5, 1'b1, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
